// File: rtl/alu_seq.sv
// Registered ALU with valid/ready issue, status flags and an
// iterative shift-add multiplier that retires one multiplier bit per cycle.
module alu_seq #(
  parameter int WIDTH       = 16,
  parameter int CONST_WIDTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic [2:0]             i_op,
  input  logic                   i_src_const,
  input  logic [WIDTH-1:0]       i_data1,
  input  logic [WIDTH-1:0]       i_data2,
  input  logic [CONST_WIDTH-1:0] i_const,
  output logic                   o_ready,
  output logic                   o_valid,
  output logic [WIDTH-1:0]       o_result,
  output logic                   o_zero,
  output logic                   o_carry,
  output logic                   o_neg,
  output logic                   o_ovf
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_SHR  = 3'd4;
  localparam logic [2:0] OP_SHL  = 3'd5;
  localparam logic [2:0] OP_MOVE = 3'd6;
  localparam logic [2:0] OP_MUL  = 3'd7;

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0]   op_a, op_b;
  logic               issue;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_cy, alu_ov;
  logic [WIDTH:0]     add_ext, sub_ext;
  logic [WIDTH:0]     shl_ext, shr_ext;

  logic [WIDTH-1:0]   a_q;
  logic [2*WIDTH-1:0] prod_q, prod_nx;
  logic [WIDTH:0]     mul_sum;
  logic [CW-1:0]      cnt_q;
  logic               last;

  assign op_a    = i_data1;
  assign op_b    = i_src_const ? WIDTH'(i_const) : i_data2;
  assign issue   = i_start && (state_q == S_IDLE);
  assign o_ready = (state_q == S_IDLE);

  assign add_ext = {1'b0, op_a} + {1'b0, op_b};
  assign sub_ext = {1'b0, op_a} - {1'b0, op_b};
  // Extra bit catches the last bit shifted out; huge shifts give 0.
  assign shl_ext = {1'b0, op_a} << op_b;
  assign shr_ext = {op_a, 1'b0} >> op_b;

  always_comb begin
    alu_res = '0;
    alu_cy  = 1'b0;
    alu_ov  = 1'b0;
    unique case (i_op)
      OP_ADD: begin
        alu_res = add_ext[WIDTH-1:0];
        alu_cy  = add_ext[WIDTH];
        alu_ov  = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                  (alu_res[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_ext[WIDTH-1:0];
        alu_cy  = sub_ext[WIDTH];
        alu_ov  = (op_a[WIDTH-1] != op_b[WIDTH-1]) &&
                  (alu_res[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_SHR: begin
        alu_res = shr_ext[WIDTH:1];
        alu_cy  = shr_ext[0];
      end
      OP_SHL: begin
        alu_res = shl_ext[WIDTH-1:0];
        alu_cy  = shl_ext[WIDTH];
      end
      OP_MOVE: alu_res = op_a;
      OP_MUL:  alu_res = '0;
      default: alu_res = '0;
    endcase
  end

  // Product register holds {partial high, remaining multiplier bits}.
  assign mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                   (prod_q[0] ? {1'b0, a_q} : '0);
  assign prod_nx = {mul_sum, prod_q[WIDTH-1:1]};
  assign last    = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (issue && i_op == OP_MUL) state_d = S_MUL;
      S_MUL:   if (last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      o_valid  <= 1'b0;
      o_result <= '0;
      o_zero   <= 1'b0;
      o_carry  <= 1'b0;
      o_neg    <= 1'b0;
      o_ovf    <= 1'b0;
    end else begin
      state_q <= state_d;
      o_valid <= 1'b0;
      if (state_q == S_MUL) begin
        prod_q <= prod_nx;
        cnt_q  <= cnt_q + CW'(1);
        if (last) begin
          o_valid  <= 1'b1;
          o_result <= prod_nx[WIDTH-1:0];
          o_zero   <= (prod_nx[WIDTH-1:0] == '0);
          o_carry  <= 1'b0;
          o_neg    <= prod_nx[WIDTH-1];
          o_ovf    <= |prod_nx[2*WIDTH-1:WIDTH];
        end
      end else if (issue) begin
        if (i_op == OP_MUL) begin
          a_q    <= op_a;
          prod_q <= {{WIDTH{1'b0}}, op_b};
          cnt_q  <= '0;
        end else begin
          o_valid  <= 1'b1;
          o_result <= alu_res;
          o_zero   <= (alu_res == '0);
          o_carry  <= alu_cy;
          o_neg    <= alu_res[WIDTH-1];
          o_ovf    <= alu_ov;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=16, CONST_WIDTH=8.
// Expected values are hand-computed constants.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic        src_const;
  logic [15:0] d1, d2;
  logic [7:0]  cst;
  logic        ready, valid;
  logic [15:0] result;
  logic        zero, carry, neg, ovf;

  int n_checks = 0;
  int n_fail   = 0;
  int busy;
  int nv;

  alu_seq #(.WIDTH(16), .CONST_WIDTH(8)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_op        (op),
    .i_src_const (src_const),
    .i_data1     (d1),
    .i_data2     (d2),
    .i_const     (cst),
    .o_ready     (ready),
    .o_valid     (valid),
    .o_result    (result),
    .o_zero      (zero),
    .o_carry     (carry),
    .o_neg       (neg),
    .o_ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // flags packed as {zero, carry, neg, ovf}
  task automatic check_out(input string tag, input logic [15:0] res,
                           input logic [3:0] flg);
    check({tag, "_valid"}, 32'(valid), 32'd1);
    check({tag, "_res"}, 32'(result), 32'(res));
    check({tag, "_flags"}, 32'({zero, carry, neg, ovf}), 32'(flg));
  endtask

  task automatic issue(input logic [2:0] o, input logic [15:0] a,
                       input logic [15:0] b, input logic sc,
                       input logic [7:0] c);
    @(negedge clk);
    op = o; d1 = a; d2 = b; src_const = sc; cst = c; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Run a MUL while pulsing i_start during the busy window.
  task automatic mul_run(input string tag, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] res,
                         input logic [3:0] flg);
    issue(3'd7, a, b, 1'b0, 8'h00);
    busy = 0;
    nv = 0;
    while (!ready && busy < 40) begin
      busy++;
      @(negedge clk);
      op = 3'd0; d1 = 16'h1111; d2 = 16'h2222;
      start = busy[0];
      @(posedge clk);
      #1;
      if (valid) nv++;
    end
    start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd16);
    check({tag, "_nvalid"}, 32'(nv), 32'd1);
    check({tag, "_ready"}, 32'(ready), 32'd1);
    check_out(tag, res, flg);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 3'd0; src_const = 1'b0;
    d1 = '0; d2 = '0; cst = '0;
    #12;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_res", 32'(result), 32'd0);
    check("rst_flags", 32'({zero, carry, neg, ovf}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(3'd0, 16'hFFFF, 16'h0001, 1'b0, 8'h00);
    check_out("add_wrap", 16'h0000, 4'b1100);
    @(posedge clk); #1;
    check("add_drop", 32'(valid), 32'd0);

    issue(3'd1, 16'h8000, 16'h1234, 1'b1, 8'h01);
    check_out("sub_const", 16'h7FFF, 4'b0001);
    issue(3'd1, 16'h0003, 16'h0005, 1'b0, 8'h00);
    check_out("sub_borrow", 16'hFFFE, 4'b0110);

    issue(3'd5, 16'h8001, 16'h0001, 1'b0, 8'h00);
    check_out("shl_1", 16'h0002, 4'b0100);
    issue(3'd5, 16'h0001, 16'h0010, 1'b0, 8'h00);
    check_out("shl_16", 16'h0000, 4'b1100);
    issue(3'd4, 16'h8001, 16'h0010, 1'b0, 8'h00);
    check_out("shr_16", 16'h0000, 4'b1100);
    issue(3'd4, 16'h8001, 16'h0011, 1'b0, 8'h00);
    check_out("shr_17", 16'h0000, 4'b1000);
    issue(3'd4, 16'h8001, 16'h0000, 1'b0, 8'h00);
    check_out("shr_0", 16'h8001, 4'b0010);
    issue(3'd4, 16'h00F3, 16'h0002, 1'b0, 8'h00);
    check_out("shr_2", 16'h003C, 4'b0100);

    issue(3'd2, 16'hF0F0, 16'hFF00, 1'b0, 8'h00);
    check_out("and", 16'hF000, 4'b0010);
    issue(3'd3, 16'h0F00, 16'h0000, 1'b1, 8'hF0);
    check_out("or_const", 16'h0FF0, 4'b0000);
    issue(3'd6, 16'h0000, 16'h0005, 1'b0, 8'h00);
    check_out("move", 16'h0000, 4'b1000);

    issue(3'd0, 16'h0001, 16'h0002, 1'b0, 8'h00);
    check_out("b2b_0", 16'h0003, 4'b0000);
    issue(3'd0, 16'h7FFF, 16'h0001, 1'b0, 8'h00);
    check_out("b2b_1", 16'h8000, 4'b0011);
    @(posedge clk); #1;
    check("b2b_drop", 32'(valid), 32'd0);

    mul_run("mul_ovf", 16'h0100, 16'h0101, 16'h0100, 4'b0001);
    @(posedge clk); #1;
    check("mul_drop", 32'(valid), 32'd0);

    mul_run("mul_ff", 16'h00FF, 16'h00FF, 16'hFE01, 4'b0010);
    issue(3'd0, 16'h000A, 16'h0014, 1'b0, 8'h00);
    check_out("add_after_mul", 16'h001E, 4'b0000);

    issue(3'd7, 16'h1234, 16'h5678, 1'b0, 8'h00);
    check("mid_busy", 32'(ready), 32'd0);
    repeat (7) @(posedge clk);
    #1;
    check("mid_still_busy", 32'(ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(ready), 32'd1);
    check("mid_rst_valid", 32'(valid), 32'd0);
    check("mid_rst_res", 32'(result), 32'd0);
    check("mid_rst_flags", 32'({zero, carry, neg, ovf}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nv = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (valid) nv++;
    end
    check("no_stale_valid", 32'(nv), 32'd0);
    check("post_rst_ready", 32'(ready), 32'd1);
    issue(3'd0, 16'h0002, 16'h0003, 1'b0, 8'h00);
    check_out("post_rst_add", 16'h0005, 4'b0000);
    @(posedge clk); #1;
    check("post_rst_drop", 32'(valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the CPU's single-cycle ALU. It adds a valid/ready issue handshake, status flags and an iterative shift-add multiplier, and generalises the datapath width and constant width. It sits between the register-file read ports and the write-back mux. The control unit issues one operation at a time and stalls on `o_ready`.

## Interface
Parameters:
- `WIDTH`, 16: datapath width; must be ≥ 2.
- `CONST_WIDTH`, 8: immediate width; must be ≤ `WIDTH`. Zero-extended to `WIDTH`.

Ports:
- `i_clk`  in  1  clock; all state on the rising edge.
- `i_rst_n`  in  1  reset, asynchronous assert, active-low.
- `i_start`  in  1  issue request; sampled only when `o_ready`=1.
- `i_op`  in  3  operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHR, 5 SHL, 6 MOVE, 7 MUL.
- `i_src_const`  in  1  0: operand B = `i_data2`; 1: operand B = zero-extended `i_const`.
- `i_data1`  in  `WIDTH`  operand A.
- `i_data2`  in  `WIDTH`  register operand B.
- `i_const`  in  `CONST_WIDTH`  immediate operand B.
- `o_ready`  out  1  block can accept `i_start` this cycle.
- `o_valid`  out  1  one-cycle pulse: `o_result`/flags updated this cycle.
- `o_result`  out  `WIDTH`  registered result; holds until the next completion.
- `o_zero`, `o_carry`, `o_neg`, `o_ovf`  out  1 each  registered flags; update together with `o_result`.

## Operation
- Issue: `i_start` && `o_ready` at a rising edge captures `i_op`, A and the selected B. Inputs are don't-care afterwards.
- `i_start` while `o_ready`=0 is ignored; no queueing.
- States:
  - IDLE: `o_ready`=1.
  - MUL: `o_ready`=0, iterating.
  - IDLE→MUL on issue of op 7.
  - MUL→IDLE after the last iteration.
  - Ops 0–6 never leave IDLE.
- ADD/SUB: modulo 2^`WIDTH`. Carry = carry out of ADD, or borrow (A<B unsigned) for SUB. Overflow = two's-complement signed overflow.
- AND/OR/MOVE: bitwise; MOVE returns A. Carry and overflow are 0.
- SHR/SHL: logical shift of A by the full `WIDTH`-bit B. Any B ≥ `WIDTH` gives 0. Carry = last bit shifted out, 0 if B=0, 0 if B > `WIDTH`. Overflow = 0.
- MUL: unsigned shift-add, one multiplier bit per cycle, LSB first, `WIDTH` iterations. Counter width is ceil(log2(`WIDTH`+1)).
  - Result = low `WIDTH` bits of A×B.
  - Overflow = 1 iff the high half of the 2·`WIDTH` product is nonzero.
  - Carry = 0.
- All ops: zero = (result == 0); neg = result MSB.
- Reset (any time, including mid-MUL): state IDLE, `o_ready`=1, `o_valid`=0, `o_result`=0, all flags 0. Any partial product is discarded.

## Timing
- Ops 0–6, issued at edge k: `o_result`/flags valid and `o_valid`=1 in the cycle after edge k. `o_valid` drops after edge k+1 unless a new op is issued at k+1.
- `o_ready` stays 1 for ops 0–6, so back-to-back issue every cycle yields `o_valid` held high, with a new result each cycle.
- MUL issued at edge k:
  - `o_ready`=0 from edge k.
  - Iterations at edges k+1 … k+`WIDTH`.
  - `o_result`/flags written and `o_valid`=1 after edge k+`WIDTH`, giving latency `WIDTH` cycles.
  - `o_ready`=1 in that same cycle, so a new op may issue in the `o_valid` cycle.
- `o_valid` is never high for more than one cycle per issued op. Exactly one `o_valid` per accepted issue.
- No combinational path from any input to any output.

## Test plan
- Reset, then ADD A=0xFFFF, B=0x0001 (`WIDTH`=16) → next cycle `o_valid`=1, result 0x0000, zero=1, carry=1, ovf=0, neg=0.
- SUB A=0x8000, const 0x01 (`i_src_const`=1) → result 0x7FFF, ovf=1, carry=0, neg=0.
- SHL A=0x8001, B=1 → 0x0002, carry=1. SHR B=16 → 0x0000, zero=1. SHR B=0 → A, carry=0.
- MUL A=0x0100, B=0x0101 → `o_ready` low exactly 16 cycles, then result 0x0100, ovf=1. `i_start` pulses during busy produce no extra `o_valid`.
- MUL 0x00FF×0x00FF → 0xFE01, ovf=0. An ADD issued in the `o_valid` cycle completes on the next cycle.
- Assert `i_rst_n`=0 at MUL iteration 7 → outputs immediately 0 and `o_ready`=1. After release, ADD 2+3 → 5 with no stale `o_valid`.
